demux1to2_stream: RTL and testbench
===================================

Name: demux1to2_stream

Overview:
- Inverse of the team's 8-bit 2:1 select path: one byte stream in, routed to one of two output streams.
- Routing is decided per packet: the select is sampled on the first beat and held until the last beat.
- Each output has a one-entry registered buffer with valid/ready handshake.
- Sits between a single-source byte producer and two independent consumers (e.g. two processing lanes).

Parameters:
- WIDTH, 8, data width of input and both outputs.
- CNT_W, 16, width of the per-output packet counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when high with in_valid.
- in_data  input  WIDTH  input beat data.
- in_last  input  1  final beat of packet.
- in_sel  input  1  destination (0 -> y0, 1 -> y1); sampled only on the first beat of a packet.
- y0_valid  output  1  output 0 beat present.
- y0_ready  input  1  consumer 0 accepts.
- y0_data  output  WIDTH  output 0 data.
- y0_last  output  1  output 0 last flag.
- y1_valid, y1_ready, y1_data, y1_last: same as y0, for output 1.
- pkt_cnt0  output  CNT_W  packets routed to y0.
- pkt_cnt1  output  CNT_W  packets routed to y1.
- busy  output  1  mid-packet (route locked).

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: y0_valid = y1_valid = 0, y0_data = y1_data = 0, y0_last = y1_last = 0, pkt_cnt0 = pkt_cnt1 = 0, busy = 0, FSM in IDLE.
- FSM states:
  - IDLE: no packet in progress.
  - ROUTE0: packet locked to y0.
  - ROUTE1: packet locked to y1.
- Effective select:
  - sel_eff = in_sel in IDLE; 0 in ROUTE0; 1 in ROUTE1.
  - in_sel is ignored outside IDLE.
- in_ready is combinational:
  - sel_eff = 0: in_ready = ~y0_valid | y0_ready.
  - sel_eff = 1: in_ready = ~y1_valid | y1_ready.
  - The combinational path from yN_ready to in_ready is permitted.
- accept = in_valid & in_ready. On accept, the selected output register loads in_data and in_last, and its valid is set next cycle. Latency: 1 cycle from accept to yN_valid.
- Non-selected output:
  - Never loaded.
  - Its contents and valid are unaffected, so it continues draining independently.
- Output register drain:
  - yN_valid clears on yN_valid & yN_ready with no load that cycle.
  - Drain and load in the same cycle: valid stays 1, new data is presented.
- Output stability: while yN_valid & ~yN_ready, yN_data and yN_last are held stable.
- Idle outputs: when yN_valid = 0, data and last keep their last value.
- FSM transitions:
  - IDLE, accept & ~in_last -> ROUTE{sel_eff}.
  - IDLE, accept & in_last -> IDLE (single-beat packet).
  - ROUTEx, accept & in_last -> IDLE.
  - Otherwise the state holds; in_valid low mid-packet holds the lock indefinitely.
- busy = (state != IDLE), registered from the state.
- Counters:
  - pkt_cntN increments by 1 in the cycle after accepting an in_last beat routed to N.
  - Wraps from 2^CNT_W-1 to 0.
  - Counting is on input acceptance, not on output drain.
- Back-to-back packets: last beat of packet A and first beat of packet B may be accepted on consecutive cycles. B's in_sel is sampled in the cycle the FSM is back in IDLE.
- Full throughput: with yN_ready held high, one beat per cycle is sustained.
- Reset mid-packet: FSM returns to IDLE, both buffers invalidated, in-flight beats discarded, counters cleared.

Test Plan:
- Reset released, in_valid = 0: all outputs 0, busy = 0, in_ready = 1.
- Single-beat packet in_sel = 1, data 0xA5, last = 1, y1_ready = 1:
  - next cycle y1_valid = 1, y1_data = 0xA5, y1_last = 1.
  - y0_valid stays 0; pkt_cnt1 = 1.
- 4-beat packet 0x10..0x13, in_sel = 0 on beat 0, then in_sel toggled on beats 1-3:
  - all four beats appear on y0 in order.
  - busy = 1 from cycle after beat 0 until cycle after beat 3.
  - pkt_cnt0 = 1.
- Backpressure, y0_ready = 0 with y0 buffer full:
  - in_ready = 0; y0_data holds stable.
  - Raising y0_ready gives drain and reload in the same cycle, no beat lost or duplicated.
- Meanwhile a pending y1 beat with y1_ready = 1 drains independently.
- Counter wrap, CNT_W = 2: five single-beat packets to y0 -> pkt_cnt0 reads 1, 2, 3, 0, 1.
- Assert rst_n low on beat 2 of a packet to y1:
  - immediately y1_valid = 0, busy = 0.
  - After release the next first beat with in_sel = 0 routes to y0.

Source files
------------

// File: rtl/demux1to2_stream.sv
// Per-packet 1:2 byte-stream demultiplexer with one-entry registered output buffers.
// The route is locked on the first beat of a packet and released after its last beat.
module demux1to2_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_sel,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y0_data,
    output logic             y0_last,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [WIDTH-1:0] y1_data,
    output logic             y1_last,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic               sel_eff_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               load0_s;
    logic               load1_s;
    logic               busy_r;
    logic               y0_valid_r;
    logic [WIDTH-1:0]   y0_data_r;
    logic               y0_last_r;
    logic               y1_valid_r;
    logic [WIDTH-1:0]   y1_data_r;
    logic               y1_last_r;
    logic [CNT_W-1:0]   pkt_cnt0_r;
    logic [CNT_W-1:0]   pkt_cnt1_r;

    // Effective destination: live select only while no packet holds the route
    always_comb begin
        sel_eff_s = in_sel;
        case (state_r)
            IDLE:    sel_eff_s = in_sel;
            ROUTE0:  sel_eff_s = 1'b0;
            ROUTE1:  sel_eff_s = 1'b1;
            default: sel_eff_s = in_sel;
        endcase
    end

    // Ready follows the selected buffer: free now, or being drained this cycle
    always_comb begin
        in_ready_s = 1'b0;
        if (sel_eff_s) begin
            in_ready_s = ~y1_valid_r | y1_ready;
        end else begin
            in_ready_s = ~y0_valid_r | y0_ready;
        end
    end

    assign accept_s = in_valid & in_ready_s;
    assign load0_s  = accept_s & ~sel_eff_s;
    assign load1_s  = accept_s & sel_eff_s;

    // Route-lock next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !in_last) begin
                    state_next_s = sel_eff_s ? ROUTE1 : ROUTE0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ROUTE0, ROUTE1: begin
                if (accept_s && in_last) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register; busy mirrors the registered state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Output buffer 0: load wins over drain so a simultaneous pair keeps valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_valid_r <= 1'b0;
            y0_data_r  <= {WIDTH{1'b0}};
            y0_last_r  <= 1'b0;
        end else if (load0_s) begin
            y0_valid_r <= 1'b1;
            y0_data_r  <= in_data;
            y0_last_r  <= in_last;
        end else if (y0_ready) begin
            y0_valid_r <= 1'b0;
        end
    end

    // Output buffer 1, same policy as buffer 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1_valid_r <= 1'b0;
            y1_data_r  <= {WIDTH{1'b0}};
            y1_last_r  <= 1'b0;
        end else if (load1_s) begin
            y1_valid_r <= 1'b1;
            y1_data_r  <= in_data;
            y1_last_r  <= in_last;
        end else if (y1_ready) begin
            y1_valid_r <= 1'b0;
        end
    end

    // Packet counters advance when a last beat is accepted, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt0_r <= {CNT_W{1'b0}};
            pkt_cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (load0_s && in_last) begin
                pkt_cnt0_r <= pkt_cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                pkt_cnt0_r <= pkt_cnt0_r;
            end
            if (load1_s && in_last) begin
                pkt_cnt1_r <= pkt_cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                pkt_cnt1_r <= pkt_cnt1_r;
            end
        end
    end

    assign in_ready = in_ready_s;
    assign y0_valid = y0_valid_r;
    assign y0_data  = y0_data_r;
    assign y0_last  = y0_last_r;
    assign y1_valid = y1_valid_r;
    assign y1_data  = y1_data_r;
    assign y1_last  = y1_last_r;
    assign pkt_cnt0 = pkt_cnt0_r;
    assign pkt_cnt1 = pkt_cnt1_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_demux1to2_stream.sv
// Bench for demux1to2_stream: vector table plus hand-written reset and counter-wrap
// sequences, with a negedge scoreboard tracking both output buffers.
module tb_demux1to2_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_sel;
    logic             y0_valid;
    logic             y0_ready;
    logic [WIDTH-1:0] y0_data;
    logic             y0_last;
    logic             y1_valid;
    logic             y1_ready;
    logic [WIDTH-1:0] y1_data;
    logic             y1_last;
    logic [CNT_W-1:0] pkt_cnt0;
    logic [CNT_W-1:0] pkt_cnt1;
    logic             busy;

    demux1to2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_sel(in_sel),
        .y0_valid(y0_valid), .y0_ready(y0_ready), .y0_data(y0_data), .y0_last(y0_last),
        .y1_valid(y1_valid), .y1_ready(y1_ready), .y1_data(y1_data), .y1_last(y1_last),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       s;
        logic       r0;
        logic       r1;
        logic       exp_rdy;
        logic       exp_busy;
    } vec_t;

    vec_t       vecs [17];
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    int         mstate;
    logic [1:0] mc0;
    logic [1:0] mc1;
    int         nvec;
    int         nfail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic s,
                         input logic r0, input logic r1);
        in_valid = v; in_data = d; in_last = l; in_sel = s;
        y0_ready = r0; y1_ready = r1;
    endtask

    // Scoreboard: compare outputs against the model, then advance the model
    task automatic monitor_step();
        logic ev0, ev1, route, erdy;
        if (!rst_n) begin
            q0.delete(); q1.delete();
            mstate = 0; mc0 = 2'd0; mc1 = 2'd0;
        end else begin
            ev0 = (q0.size() != 0);
            ev1 = (q1.size() != 0);
            chk("y0_valid", {31'd0, y0_valid}, {31'd0, ev0});
            chk("y1_valid", {31'd0, y1_valid}, {31'd0, ev1});
            if (ev0) chk("y0_beat", {23'd0, y0_last, y0_data}, {23'd0, q0[0]});
            if (ev1) chk("y1_beat", {23'd0, y1_last, y1_data}, {23'd0, q1[0]});
            chk("busy", {31'd0, busy}, {31'd0, (mstate != 0)});
            chk("pkt_cnt0", {30'd0, pkt_cnt0}, {30'd0, mc0});
            chk("pkt_cnt1", {30'd0, pkt_cnt1}, {30'd0, mc1});
            route = (mstate == 0) ? in_sel : (mstate == 2);
            erdy  = route ? (!ev1 || y1_ready) : (!ev0 || y0_ready);
            chk("in_ready", {31'd0, in_ready}, {31'd0, erdy});
            if (ev0 && y0_ready) void'(q0.pop_front());
            if (ev1 && y1_ready) void'(q1.pop_front());
            if (in_valid && erdy) begin
                if (route) q1.push_back({in_last, in_data});
                else       q0.push_back({in_last, in_data});
                if (in_last) begin
                    mstate = 0;
                    if (route) mc1 = mc1 + 2'd1;
                    else       mc0 = mc0 + 2'd1;
                end else if (mstate == 0) begin
                    mstate = route ? 2 : 1;
                end
            end
        end
    endtask

    initial begin
        logic [1:0] wrap_exp [5];
        nvec = 0; nfail = 0;
        mstate = 0; mc0 = 2'd0; mc1 = 2'd0;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        //           v     data   last  sel   r0    r1    rdy   busy
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'h30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_y0_valid", {31'd0, y0_valid}, 32'd0);
        chk("rst_y1_valid", {31'd0, y1_valid}, 32'd0);
        chk("rst_data", {14'd0, y1_last, y1_data, y0_last, y0_data}, 32'd0);
        chk("rst_cnts", {28'd0, pkt_cnt1, pkt_cnt0}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1 drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].s, vecs[i].r0, vecs[i].r1);
            #1;
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_rdy});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
        end

        // Reset asserted while beat 2 of a y1 packet is offered
        @(posedge clk); #1 drive(1'b1, 8'h50, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1 drive(1'b1, 8'h51, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1 drive(1'b1, 8'h52, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_y1_valid", {31'd0, y1_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_y1_valid", {31'd0, y1_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_cnts", {28'd0, pkt_cnt1, pkt_cnt0}, 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Five single-beat packets to y0; the first also proves post-reset routing
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 drive(1'b1, 8'h60 + 8'(k), 1'b1, 1'b0, 1'b1, 1'b1);
            @(posedge clk); #1 drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("wrap%0d_cnt0", k), {30'd0, pkt_cnt0}, {30'd0, wrap_exp[k]});
            chk($sformatf("wrap%0d_y0", k), {22'd0, y1_valid, y0_valid, y0_data},
                {22'd0, 1'b0, 1'b1, 8'h60 + 8'(k)});
        end

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
